// File: rtl/cmd_deframer.sv
// Byte-stream deframer: hunts for a 32-bit marker, then assembles the following 32-bit command word.
// Build option CMD_CRC_EN appends an XOR check byte (XOR of the 8 frame bytes) that must match before delivery.
module cmd_deframer #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter logic [31:0] MAGIC   = 32'hF0AA550F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  output logic [31:0] o_cmd_magic,
  output logic [31:0] o_cmd_command,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic        o_sync_err,
  output logic [7:0]  o_err_cnt
);

  // state | meaning
  // HUNT  | searching for marker; idx = marker bytes matched so far
  // CMD   | collecting command bytes; idx = bytes received so far
  // CHK   | waiting for the XOR check byte (CMD_CRC_EN builds only)
  // OUT   | command word presented, waiting for the consumer
`ifdef CMD_CRC_EN
  typedef enum logic [1:0] {HUNT = 2'd0, CMD = 2'd1, CHK = 2'd2, OUT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, CMD = 2'd1, OUT = 2'd3} state_t;
`endif

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] idle_cnt, idle_nxt;
  logic        accept, active, err_set, cmd_shift, enter_out;
  logic [7:0]  magic_byte;

  assign o_byte_rdy = !rst && (state != OUT);
  assign accept     = i_byte_vld && o_byte_rdy;

  always_comb begin
    magic_byte = MAGIC[31:24];
    case (idx)
      2'd1:    magic_byte = MAGIC[23:16];
      2'd2:    magic_byte = MAGIC[15:8];
      2'd3:    magic_byte = MAGIC[7:0];
      default: magic_byte = MAGIC[31:24];
    endcase
  end

`ifdef CMD_CRC_EN
  localparam logic [7:0] MAGIC_XOR = MAGIC[31:24] ^ MAGIC[23:16] ^ MAGIC[15:8] ^ MAGIC[7:0];
  logic [7:0] cmd_xor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cmd_xor <= '0;
    else if (cmd_shift)
      cmd_xor <= (idx == 2'd0) ? i_byte : (cmd_xor ^ i_byte);
  end
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    idle_nxt  = '0;
    err_set   = 1'b0;
    cmd_shift = 1'b0;
    enter_out = 1'b0;
    active    = 1'b0;
    case (state)
      HUNT: begin
        active = (idx != 2'd0);
        if (accept) begin
          if (i_byte == magic_byte) begin
            idx_nxt = idx + 2'd1;
            if (idx == 2'd3) state_nxt = CMD;
          end else begin
            // a fresh leading marker byte restarts the match at 1
            idx_nxt = (i_byte == MAGIC[31:24]) ? 2'd1 : 2'd0;
          end
        end
      end
      CMD: begin
        active = 1'b1;
        if (accept) begin
          cmd_shift = 1'b1;
          idx_nxt   = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef CMD_CRC_EN
            state_nxt = CHK;
`else
            state_nxt = OUT;
            enter_out = 1'b1;
`endif
          end
        end
      end
`ifdef CMD_CRC_EN
      CHK: begin
        active = 1'b1;
        if (accept) begin
          if (i_byte == (MAGIC_XOR ^ cmd_xor)) begin
            state_nxt = OUT;
            enter_out = 1'b1;
          end else begin
            state_nxt = HUNT;
            err_set   = 1'b1;
          end
        end
      end
`endif
      OUT: if (i_cmd_rdy) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    // an accepted byte always beats the timeout
    if (!accept && active) begin
      if (idle_cnt >= TIMEOUT) begin
        state_nxt = HUNT;
        idx_nxt   = 2'd0;
        err_set   = 1'b1;
      end else begin
        idle_nxt = idle_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      idx      <= 2'd0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cmd_magic   <= '0;
      o_cmd_command <= '0;
      o_cmd_vld     <= 1'b0;
      o_sync_err    <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      o_sync_err <= err_set;
      if (err_set && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'd1;
      if (cmd_shift)
        o_cmd_command <= {o_cmd_command[23:0], i_byte};
      if (enter_out) begin
        o_cmd_magic <= MAGIC;
        o_cmd_vld   <= 1'b1;
      end else if ((state == OUT) && i_cmd_rdy) begin
        o_cmd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cmd_deframer.md
CMD_DEFRAMER -- requirements
Module: cmd_deframer

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16'd50000: cycles allowed between bytes of a partial frame before it is abandoned.
REQ-002 SHALL provide parameter MAGIC, default 32'hF0AA550F: frame marker, sent MSB byte first.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_byte  input  8  received byte from the host link FIFO.
REQ-006 SHALL have port i_byte_vld  input  1  i_byte valid.
REQ-007 SHALL have port o_byte_rdy  output  1  byte accepted when i_byte_vld && o_byte_rdy.
REQ-008 SHALL have port o_cmd_magic  output  32  assembled marker word to the parameter store.
REQ-009 SHALL have port o_cmd_command  output  32  assembled command word: bit 31 global, 30:29 channel, 28:27 slot, 26:23 opcode.
REQ-010 SHALL have port o_cmd_vld  output  1  command word valid.
REQ-011 SHALL have port i_cmd_rdy  input  1  consumer accepts when o_cmd_vld && i_cmd_rdy.
REQ-012 SHALL have port o_sync_err  output  1  one-cycle pulse on abandoned or rejected frame.
REQ-013 SHALL have port o_err_cnt  output  8  saturating count of o_sync_err pulses.

Function
REQ-014 SHALL implement states HUNT, CMD, CHK, OUT; a byte index 0..3 is kept within HUNT and CMD.
REQ-015 In HUNT, an accepted byte equal to MAGIC byte[index] SHALL advance index; after byte 3 matches, the state SHALL go to CMD with index 0.
REQ-016 In HUNT, on a mismatch the index SHALL go to 1 if the byte equals MAGIC[31:24], else to 0; no error SHALL be flagged.
REQ-017 In CMD, accepted bytes SHALL fill o_cmd_command MSB first; after the 4th byte the state SHALL go to CHK if CMD_CRC_EN is defined, else to OUT.
REQ-018 On entry to OUT, o_cmd_magic SHALL equal MAGIC and o_cmd_vld SHALL be 1 on the cycle after the last byte is accepted (1-cycle latency).
REQ-019 In OUT, o_cmd_vld, o_cmd_magic and o_cmd_command SHALL hold stable until i_cmd_rdy=1; the next cycle SHALL be HUNT with index 0 and o_cmd_vld=0.
REQ-020 o_byte_rdy SHALL be 1 in HUNT, CMD and CHK, and 0 in OUT (no bypass).
REQ-021 A 16-bit idle counter SHALL clear on every accepted byte and on entry to HUNT index 0, and increment otherwise while in (HUNT index>0), CMD or CHK.
REQ-022 When the idle counter reaches TIMEOUT, the block SHALL return to HUNT index 0 and pulse o_sync_err for one cycle; OUT SHALL never time out.
REQ-023 A HUNT mismatch with index>0 SHALL NOT count as a timeout or an error.
REQ-024 o_err_cnt SHALL increment by 1 per o_sync_err pulse and saturate at 8'd255.
REQ-025 If a byte is accepted in the same cycle the idle counter reaches TIMEOUT, the byte SHALL win: it is processed and the counter clears.

Reset
REQ-026 While rst=1: state HUNT, index 0, idle counter 0, o_cmd_magic=0, o_cmd_command=0, o_cmd_vld=0, o_sync_err=0, o_err_cnt=0, o_byte_rdy=0.
REQ-027 Reset asserted mid-frame or in OUT SHALL discard the frame; the first byte accepted after release SHALL be treated as MAGIC byte 0 candidate.

Configuration
REQ-028 With macro CMD_CRC_EN defined, CHK SHALL accept one byte compared with the XOR of the 8 frame bytes: on match go to OUT; on mismatch go to HUNT index 0, pulse o_sync_err, and leave o_cmd_vld low.
REQ-029 Without CMD_CRC_EN, the CHK state and XOR logic SHALL be absent and frames SHALL be 8 bytes.

Verification
REQ-030 Bytes F0 AA 55 0F 83 00 00 2A streamed back to back, i_cmd_rdy=1 -> o_cmd_vld for 1 cycle, o_cmd_command=32'h8300002A, one cycle after the last byte.
REQ-031 Bytes 12 F0 F0 AA 55 0F + 4 command bytes -> correct frame decoded, o_err_cnt stays 0.
REQ-032 i_cmd_rdy=0 for 10 cycles in OUT -> o_cmd_vld and data stable, o_byte_rdy=0 throughout, then one handshake.
REQ-033 TIMEOUT=20, stall after 6 bytes -> o_sync_err pulse at idle count 20, o_err_cnt=1, next full frame decodes.
REQ-034 CMD_CRC_EN defined, wrong check byte -> no o_cmd_vld, o_sync_err pulse; correct check byte (XOR of the 8 bytes) -> frame delivered.
REQ-035 300 forced timeouts -> o_err_cnt=255; rst pulse mid-frame -> all outputs 0 and no stale frame is delivered.
